// File: rtl/spi_target.sv
// SPI mode-0 responder: MSB-first 8-bit frames, pins oversampled through synchronisers,
// one-byte RX holding register and one-byte TX buffer facing the peripheral bus.
module spi_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck_in,
  input  logic       spi_cs_n_in,
  input  logic       spi_mosi_in,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_write,
  output logic       tx_full,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       overrun,
  input  logic       clear_status,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, cs_n_s, mosi_s, sck_rise, sck_fall;

  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_tx_q, shift_tx_d;
  logic [7:0] shift_rx_q, shift_rx_d;
  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       tx_load, byte_done;

  // Chains preset to the idle bus so a CS held low across reset reads as a fresh frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_in};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    tx_load    = 1'b0;
    byte_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!cs_n_s) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = 3'd0;
          tx_load   = 1'b1;
        end
      end
      default: begin
        if (cs_n_s) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
        end else if (sck_rise) begin
          shift_rx_d = {shift_rx_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          byte_done  = (bit_cnt_q == 3'd7);
        end else if (sck_fall) begin
          // Falling edge at bit 0 is the byte boundary: present the next TX byte.
          if (bit_cnt_q == 3'd0) tx_load = 1'b1;
          else                   shift_tx_d = shift_tx_q << 1;
        end
      end
    endcase

    if (tx_load) shift_tx_d = tx_full_q ? tx_buf_q : 8'hFF;

    // Writes land after the shifter has taken the old buffer, so a same-cycle write survives.
    tx_buf_d  = tx_write ? tx_data : tx_buf_q;
    tx_full_d = tx_full_q;
    if (tx_load)  tx_full_d = 1'b0;
    if (tx_write) tx_full_d = 1'b1;

    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_read;
    overrun_d  = overrun_q & ~clear_status;
    if (byte_done) begin
      rx_data_d  = {shift_rx_q[6:0], mosi_s};
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_read) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_tx_q <= 8'hFF;
      shift_rx_q <= 8'h00;
      tx_buf_q   <= 8'h00;
      tx_full_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // busy is the FSM state itself (ACTIVE = 1).
  assign busy        = (state_q == ST_ACTIVE);
  assign spi_miso_oe = busy;
  assign spi_miso    = shift_tx_q[7];
  assign tx_full     = tx_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI host model drives the pins, each scenario task
// compares outputs with hand-computed values.
module tb_spi_target;

  localparam int SYNC = 2;
  localparam int H    = SYNC + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sck_in, spi_cs_n_in, spi_mosi_in;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_write, tx_full;
  logic [7:0] rx_data;
  logic       rx_valid, rx_read, overrun, clear_status, busy;

  int vectors    = 0;
  int miscompares = 0;

  spi_target #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst),
    .spi_sck_in(spi_sck_in), .spi_cs_n_in(spi_cs_n_in), .spi_mosi_in(spi_mosi_in),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_read(rx_read),
    .overrun(overrun), .clear_status(clear_status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_tx_write(input logic [7:0] d);
    tx_data = d; tx_write = 1'b1; wait_clks(1); tx_write = 1'b0;
  endtask

  task automatic pulse_rx_read;
    rx_read = 1'b1; wait_clks(1); rx_read = 1'b0;
  endtask

  task automatic pulse_clear;
    clear_status = 1'b1; wait_clks(1); clear_status = 1'b0;
  endtask

  task automatic cs_low;
    spi_cs_n_in = 1'b0; wait_clks(H);
  endtask

  task automatic cs_high;
    spi_cs_n_in = 1'b1; wait_clks(H);
  endtask

  // Mode-0 host: set MOSI while SCK low, sample MISO just before the rising edge.
  // rd_strobe raises rx_read exactly on the cycle the last rising edge completes the byte.
  task automatic host_bits(input logic [7:0] out_b, input int nbits, input bit rd_strobe,
                           output logic [7:0] in_b);
    in_b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi_in = out_b[7-i];
      wait_clks(H);
      in_b[7-i] = spi_miso;
      spi_sck_in = 1'b1;
      for (int k = 0; k < H; k++) begin
        @(posedge clk); #1;
        if (rd_strobe && i == nbits - 1) rx_read = (k == SYNC - 1);
      end
      spi_sck_in = 1'b0;
    end
    wait_clks(H);
    spi_mosi_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wait_clks(3);
    rst = 1'b0; wait_clks(2);
    vectors++; if (spi_miso !== 1'b1) begin miscompares++; $display("FAIL reset_miso got %b want 1", spi_miso); end
    vectors++; if (spi_miso_oe !== 1'b0) begin miscompares++; $display("FAIL reset_oe got %b want 0", spi_miso_oe); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    vectors++; if (tx_full !== 1'b0) begin miscompares++; $display("FAIL reset_tx_full got %b want 0", tx_full); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_tx_byte;
    logic [7:0] m;
    pulse_tx_write(8'h3C);
    vectors++; if (tx_full !== 1'b1) begin miscompares++; $display("FAIL t1_tx_full_set got %b want 1", tx_full); end
    cs_low();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t1_busy got %b want 1", busy); end
    vectors++; if (spi_miso_oe !== 1'b1) begin miscompares++; $display("FAIL t1_oe got %b want 1", spi_miso_oe); end
    vectors++; if (tx_full !== 1'b0) begin miscompares++; $display("FAIL t1_tx_full_taken got %b want 0", tx_full); end
    host_bits(8'hA5, 8, 1'b0, m);
    vectors++; if (m !== 8'h3C) begin miscompares++; $display("FAIL t1_miso got %h want 3c", m); end
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL t1_rx_data got %h want a5", rx_data); end
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL t1_rx_valid got %b want 1", rx_valid); end
    cs_high();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t1_busy_end got %b want 0", busy); end
    vectors++; if (spi_miso_oe !== 1'b0) begin miscompares++; $display("FAIL t1_oe_end got %b want 0", spi_miso_oe); end
    pulse_rx_read();
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL t1_rx_read got %b want 0", rx_valid); end
  endtask

  task automatic test_idle_fill;
    logic [7:0] m;
    cs_low();
    host_bits(8'h12, 8, 1'b0, m);
    vectors++; if (m !== 8'hFF) begin miscompares++; $display("FAIL t2_miso0 got %h want ff", m); end
    vectors++; if (rx_data !== 8'h12) begin miscompares++; $display("FAIL t2_rx0 got %h want 12", rx_data); end
    pulse_rx_read();
    host_bits(8'h34, 8, 1'b0, m);
    vectors++; if (m !== 8'hFF) begin miscompares++; $display("FAIL t2_miso1 got %h want ff", m); end
    vectors++; if (rx_data !== 8'h34) begin miscompares++; $display("FAIL t2_rx1 got %h want 34", rx_data); end
    pulse_rx_read();
    cs_high();
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL t2_overrun got %b want 0", overrun); end
  endtask

  task automatic test_overrun;
    logic [7:0] m;
    cs_low();
    host_bits(8'h11, 8, 1'b0, m);
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL t3_overrun_early got %b want 0", overrun); end
    host_bits(8'h22, 8, 1'b0, m);
    cs_high();
    vectors++; if (rx_data !== 8'h22) begin miscompares++; $display("FAIL t3_rx_data got %h want 22", rx_data); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL t3_overrun got %b want 1", overrun); end
    pulse_clear();
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL t3_clear got %b want 0", overrun); end
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL t3_rx_valid got %b want 1", rx_valid); end
    pulse_rx_read();
  endtask

  task automatic test_back_to_back;
    logic [7:0] a, b, m;
    pulse_tx_write(8'h81);
    cs_low();
    host_bits(8'h0F, 4, 1'b0, a);
    pulse_tx_write(8'h42);
    vectors++; if (tx_full !== 1'b1) begin miscompares++; $display("FAIL t7_tx_full_mid got %b want 1", tx_full); end
    host_bits(8'hF0, 4, 1'b0, b);
    vectors++; if ({a[7:4], b[7:4]} !== 8'h81) begin miscompares++; $display("FAIL t7_miso0 got %h want 81", {a[7:4], b[7:4]}); end
    vectors++; if (rx_data !== 8'h0F) begin miscompares++; $display("FAIL t7_rx0 got %h want 0f", rx_data); end
    vectors++; if (tx_full !== 1'b0) begin miscompares++; $display("FAIL t7_tx_full_taken got %b want 0", tx_full); end
    host_bits(8'h5A, 8, 1'b0, m);
    vectors++; if (m !== 8'h42) begin miscompares++; $display("FAIL t7_miso1 got %h want 42", m); end
    vectors++; if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL t7_rx1 got %h want 5a", rx_data); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL t7_overrun got %b want 1", overrun); end
    cs_high();
    pulse_clear();
    pulse_rx_read();
  endtask

  task automatic test_partial_frame;
    logic [7:0] m;
    cs_low();
    host_bits(8'hF8, 5, 1'b0, m);
    cs_high();
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL t4_rx_valid_partial got %b want 0", rx_valid); end
    vectors++; if (rx_data !== 8'h5A) begin miscompares++; $display("FAIL t4_rx_data_kept got %h want 5a", rx_data); end
    cs_low();
    host_bits(8'h7E, 8, 1'b0, m);
    cs_high();
    vectors++; if (rx_data !== 8'h7E) begin miscompares++; $display("FAIL t4_rx_data got %h want 7e", rx_data); end
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL t4_rx_valid got %b want 1", rx_valid); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] m;
    cs_low();
    host_bits(8'h00, 1, 1'b0, m);
    pulse_tx_write(8'h99);
    host_bits(8'h00, 2, 1'b0, m);
    rst = 1'b1; wait_clks(1);
    vectors++; if (spi_miso !== 1'b1) begin miscompares++; $display("FAIL t5_miso got %b want 1", spi_miso); end
    vectors++; if (spi_miso_oe !== 1'b0) begin miscompares++; $display("FAIL t5_oe got %b want 0", spi_miso_oe); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL t5_rx_data got %h want 00", rx_data); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL t5_rx_valid got %b want 0", rx_valid); end
    vectors++; if (tx_full !== 1'b0) begin miscompares++; $display("FAIL t5_tx_full got %b want 0", tx_full); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL t5_busy got %b want 0", busy); end
    wait_clks(1);
    rst = 1'b0; wait_clks(H);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t5_refall_busy got %b want 1", busy); end
    host_bits(8'hC3, 8, 1'b0, m);
    vectors++; if (m !== 8'hFF) begin miscompares++; $display("FAIL t5_miso_after got %h want ff", m); end
    cs_high();
    vectors++; if (rx_data !== 8'hC3) begin miscompares++; $display("FAIL t5_rx_after got %h want c3", rx_data); end
  endtask

  task automatic test_read_collision;
    logic [7:0] m;
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL t6_pre_valid got %b want 1", rx_valid); end
    cs_low();
    host_bits(8'h55, 8, 1'b1, m);
    rx_read = 1'b0;
    cs_high();
    vectors++; if (rx_data !== 8'h55) begin miscompares++; $display("FAIL t6_rx_data got %h want 55", rx_data); end
    vectors++; if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL t6_rx_valid got %b want 1", rx_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL t6_overrun got %b want 0", overrun); end
  endtask

  initial begin
    rst = 1'b1;
    spi_sck_in = 1'b0; spi_cs_n_in = 1'b1; spi_mosi_in = 1'b0;
    tx_data = 8'h00; tx_write = 1'b0; rx_read = 1'b0; clear_status = 1'b0;
    test_reset();
    test_tx_byte();
    test_idle_fill();
    test_overrun();
    test_back_to_back();
    test_partial_frame();
    test_reset_mid_frame();
    test_read_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
